// File: rtl/code_lock_ctrl.sv
// Keypad code lock: digit entry, code compare with attempt limiting and lockout,
// entry timeout, reprogrammable code, and a status/LED front panel.
module code_lock_ctrl #(
  parameter int NDIG         = 4,
  parameter int DIG_W        = 4,
  parameter int MAX_ATTEMPTS = 2,
  parameter int TICK_DIV     = 50000,
  parameter int TIMEOUT_MS   = 30000,
  parameter int PAUSE_MS     = 20000,
  parameter int BLINK_MS     = 500,
  parameter logic [NDIG*DIG_W-1:0] CODE_INIT = 16'h3283
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIG_W-1:0]      switch,
  input  logic [NDIG-1:0]       btn,
  input  logic                  latch,
  input  logic                  lock,
  input  logic                  prog,
  output logic [NDIG*DIG_W-1:0] entry,
  output logic [2:0]            status,
  output logic [7:0]            led,
  output logic [3:0]            attempts,
  output logic                  unlocked
);

  localparam int CW     = NDIG * DIG_W;
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_A   = (TIMEOUT_MS > PAUSE_MS) ? TIMEOUT_MS : PAUSE_MS;
  localparam int MS_MAX = (MS_A > BLINK_MS) ? MS_A : BLINK_MS;
  localparam int TW     = $clog2(MS_MAX + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_MS);
  localparam logic [TW-1:0] T_PAUSE   = TW'(PAUSE_MS);
  localparam logic [TW-1:0] T_BLINK   = TW'(BLINK_MS);
  localparam logic [3:0]    ATT_LAST  = 4'(MAX_ATTEMPTS - 1);

  typedef enum logic [1:0] {S_LOCKED, S_UNLOCKED, S_PAUSE, S_PROGRAM} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   code_q, code_d, entry_q, entry_d;
  logic [3:0]      att_q, att_d;
  logic [TW-1:0]   timer_q, timer_d, timer_dec;
  logic            armed_q, armed_d, blink_q, blink_d;
  logic [7:0]      led_q, led_d;
  logic [PW-1:0]   pre_cnt;
  logic            tick, tick_last;
  logic            edge_en, latch_q, lock_q, prog_q;
  logic            latch_fall, lock_fall, prog_rise;
  logic [3:0]      sw4;

  generate
    if (DIG_W >= 4) begin : g_sw_trunc
      assign sw4 = switch[3:0];
    end else begin : g_sw_ext
      assign sw4 = {{(4 - DIG_W){1'b0}}, switch};
    end
  endgenerate

  // Until the first clock after reset the "previous" level is the live input,
  // so a control held low through reset never looks like an edge.
  assign latch_fall = (edge_en ? latch_q : latch) & ~latch;
  assign lock_fall  = (edge_en ? lock_q  : lock)  & ~lock;
  assign prog_rise  = ~(edge_en ? prog_q : prog)  &  prog;

  assign tick      = (pre_cnt == PRE_LAST);
  assign tick_last = tick && (timer_q <= TW'(1));
  assign timer_dec = (tick && (timer_q != '0)) ? timer_q - 1'b1 : timer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      edge_en <= 1'b0;
      latch_q <= 1'b0;
      lock_q  <= 1'b0;
      prog_q  <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      edge_en <= 1'b1;
      latch_q <= latch;
      lock_q  <= lock;
      prog_q  <= prog;
    end
  end

  function automatic logic [CW-1:0] load_digits(input logic [CW-1:0] base,
                                                input logic [NDIG-1:0] sel,
                                                input logic [DIG_W-1:0] val);
    logic [CW-1:0] r;
    r = base;
    for (int i = 0; i < NDIG; i++) begin
      if (sel[i]) r[i*DIG_W +: DIG_W] = val;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOCKED;
      code_q  <= CODE_INIT;
      entry_q <= '0;
      att_q   <= '0;
      timer_q <= '0;
      armed_q <= 1'b0;
      blink_q <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      entry_q <= entry_d;
      att_q   <= att_d;
      timer_q <= timer_d;
      armed_q <= armed_d;
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    entry_d = entry_q;
    att_d   = att_q;
    timer_d = timer_dec;
    armed_d = armed_q;
    blink_d = blink_q;
    case (state_q)
      S_LOCKED: begin
        if (lock_fall) begin
          entry_d = '0;
          att_d   = '0;
          armed_d = 1'b0;
          timer_d = '0;
        end else if (latch_fall) begin
          entry_d = '0;
          armed_d = 1'b0;
          timer_d = '0;
          if (entry_q == code_q) begin
            state_d = S_UNLOCKED;
            att_d   = '0;
            timer_d = T_BLINK;
            blink_d = 1'b1;
          end else if (att_q == ATT_LAST) begin
            state_d = S_PAUSE;
            att_d   = '0;
            timer_d = T_PAUSE;
          end else begin
            att_d = att_q + 4'd1;
          end
        end else begin
          if (armed_q && tick_last) begin
            entry_d = '0;
            armed_d = 1'b0;
            timer_d = '0;
          end
          // Only the first digit of an entry starts the timeout window.
          if (btn != '0) begin
            entry_d = load_digits(entry_d, btn, switch);
            if (!armed_d) begin
              armed_d = 1'b1;
              timer_d = T_TIMEOUT;
            end
          end
        end
      end
      S_UNLOCKED: begin
        if (lock_fall) begin
          state_d = S_LOCKED;
          entry_d = '0;
          att_d   = '0;
          armed_d = 1'b0;
          timer_d = '0;
          blink_d = 1'b0;
        end else if (prog_rise) begin
          state_d = S_PROGRAM;
          entry_d = '0;
          timer_d = '0;
        end else if (tick_last) begin
          blink_d = ~blink_q;
          timer_d = T_BLINK;
        end
      end
      S_PAUSE: begin
        if (tick_last) begin
          state_d = S_LOCKED;
          timer_d = '0;
        end
      end
      S_PROGRAM: begin
        if (lock_fall) begin
          state_d = S_LOCKED;
          entry_d = '0;
          att_d   = '0;
          armed_d = 1'b0;
          timer_d = '0;
          blink_d = 1'b0;
        end else if (latch_fall) begin
          state_d = S_UNLOCKED;
          code_d  = entry_q;
          entry_d = '0;
          timer_d = T_BLINK;
          blink_d = 1'b1;
        end else if (btn != '0) begin
          entry_d = load_digits(entry_q, btn, switch);
        end
      end
      default: state_d = S_LOCKED;
    endcase

    // led is registered so it reads 0 during reset; in LOCKED it mirrors the panel one cycle late.
    case (state_d)
      S_LOCKED:   led_d = {2'b00, lock, latch, sw4};
      S_UNLOCKED: led_d = {8{blink_d}};
      default:    led_d = 8'h00;
    endcase
  end

  always_comb begin
    case (state_q)
      S_LOCKED:   status = armed_q ? 3'd4 : 3'd0;
      S_UNLOCKED: status = 3'd1;
      S_PAUSE:    status = 3'd2;
      S_PROGRAM:  status = 3'd3;
      default:    status = 3'd0;
    endcase
    unlocked = (state_q == S_UNLOCKED) || (state_q == S_PROGRAM);
  end

  assign entry    = entry_q;
  assign attempts = att_q;
  assign led      = led_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl: a per-cycle vector table plus hand-written
// multi-cycle sequences for blink, lockout, timeout, programming and reset.
module tb_code_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  switch;
  logic [3:0]  btn;
  logic        latch, lock, prog;
  logic [15:0] entry;
  logic [2:0]  status;
  logic [7:0]  led;
  logic [3:0]  attempts;
  logic        unlocked;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0]  btn;
    logic [3:0]  sw;
    logic        latch;
    logic        lock;
    logic        prog;
    logic [15:0] e_entry;
    logic [2:0]  e_status;
    logic [3:0]  e_att;
    logic        e_unl;
    logic [7:0]  e_led;
  } vec_t;

  vec_t tbl[21];

  code_lock_ctrl #(
    .NDIG(4), .DIG_W(4), .MAX_ATTEMPTS(2), .TICK_DIV(4),
    .TIMEOUT_MS(10), .PAUSE_MS(8), .BLINK_MS(2), .CODE_INIT(16'h3283)
  ) dut (
    .clk(clk), .rst_n(rst_n), .switch(switch), .btn(btn), .latch(latch),
    .lock(lock), .prog(prog), .entry(entry), .status(status), .led(led),
    .attempts(attempts), .unlocked(unlocked)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // drivers
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int d, input logic [3:0] v);
    btn = 4'(1 << d);
    switch = v;
    cyc(1);
    btn = 4'h0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int d = 3; d >= 0; d--) load(d, c[d*4 +: 4]);
  endtask

  task automatic latch_pulse();
    latch = 1'b0;
    cyc(1);
    latch = 1'b1;
    cyc(1);
  endtask

  task automatic lock_pulse();
    lock = 1'b0;
    cyc(1);
    lock = 1'b1;
    cyc(1);
  endtask

  initial begin
    int n;
    logic [7:0] prev;

    tbl[0]  = '{4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 4'd0, 1'b0, 8'h30};
    tbl[1]  = '{4'h8, 4'h3, 1'b1, 1'b1, 1'b0, 16'h3000, 3'd4, 4'd0, 1'b0, 8'h33};
    tbl[2]  = '{4'h4, 4'h2, 1'b1, 1'b1, 1'b0, 16'h3200, 3'd4, 4'd0, 1'b0, 8'h32};
    tbl[3]  = '{4'h2, 4'h8, 1'b1, 1'b1, 1'b0, 16'h3280, 3'd4, 4'd0, 1'b0, 8'h38};
    tbl[4]  = '{4'h1, 4'h3, 1'b1, 1'b1, 1'b0, 16'h3283, 3'd4, 4'd0, 1'b0, 8'h33};
    tbl[5]  = '{4'h0, 4'h3, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd1, 4'd0, 1'b1, 8'hFF};
    tbl[6]  = '{4'h0, 4'h3, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd1, 4'd0, 1'b1, 8'hFF};
    tbl[7]  = '{4'h0, 4'h3, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 1'b0, 8'h13};
    tbl[8]  = '{4'h0, 4'h3, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 4'd0, 1'b0, 8'h33};
    tbl[9]  = '{4'hF, 4'h1, 1'b1, 1'b1, 1'b0, 16'h1111, 3'd4, 4'd0, 1'b0, 8'h31};
    tbl[10] = '{4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 4'd1, 1'b0, 8'h21};
    tbl[11] = '{4'h0, 4'h1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 4'd1, 1'b0, 8'h31};
    tbl[12] = '{4'h3, 4'h5, 1'b1, 1'b1, 1'b0, 16'h0055, 3'd4, 4'd1, 1'b0, 8'h35};
    tbl[13] = '{4'h0, 4'h5, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 1'b0, 8'h15};
    tbl[14] = '{4'h0, 4'h5, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 4'd0, 1'b0, 8'h35};
    tbl[15] = '{4'h8, 4'h3, 1'b1, 1'b1, 1'b0, 16'h3000, 3'd4, 4'd0, 1'b0, 8'h33};
    tbl[16] = '{4'h4, 4'h2, 1'b1, 1'b1, 1'b0, 16'h3200, 3'd4, 4'd0, 1'b0, 8'h32};
    tbl[17] = '{4'h2, 4'h8, 1'b1, 1'b1, 1'b0, 16'h3280, 3'd4, 4'd0, 1'b0, 8'h38};
    tbl[18] = '{4'h1, 4'h3, 1'b1, 1'b1, 1'b0, 16'h3283, 3'd4, 4'd0, 1'b0, 8'h33};
    tbl[19] = '{4'h0, 4'h3, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 1'b0, 8'h03};
    tbl[20] = '{4'h0, 4'h3, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 4'd0, 1'b0, 8'h33};

    rst_n = 1'b0;
    btn = 4'h0; switch = 4'h0; latch = 1'b1; lock = 1'b1; prog = 1'b0;
    cyc(3);
    check("rst_status", status, 3'd0);
    check("rst_entry", entry, 16'h0);
    check("rst_led", led, 8'h0);
    check("rst_attempts", attempts, 4'd0);
    check("rst_unlocked", unlocked, 1'b0);
    rst_n = 1'b1;

    // Vector table: unlock, relock, wrong code, multi-digit load, lock/latch collision
    for (int i = 0; i < 21; i++) begin
      btn = tbl[i].btn; switch = tbl[i].sw; latch = tbl[i].latch;
      lock = tbl[i].lock; prog = tbl[i].prog;
      cyc(1);
      check($sformatf("v%0d_entry", i), entry, tbl[i].e_entry);
      check($sformatf("v%0d_status", i), status, tbl[i].e_status);
      check($sformatf("v%0d_attempts", i), attempts, tbl[i].e_att);
      check($sformatf("v%0d_unlocked", i), unlocked, tbl[i].e_unl);
      check($sformatf("v%0d_led", i), led, tbl[i].e_led);
    end
    btn = 4'h0;

    // Blink in UNLOCKED: FF on entry, then toggles every 8 cycles
    enter_code(16'h3283);
    latch_pulse();
    check("blink_unlock_status", status, 3'd1);
    check("blink_start_led", led, 8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    prev = led; n = 0;
    while (led == prev && n < 20) begin cyc(1); n++; end
    check("blink_first_val", led, exp_q.pop_front());
    for (int k = 0; k < 2; k++) begin
      prev = led; n = 0;
      while (led == prev && n < 20) begin cyc(1); n++; end
      check($sformatf("blink_period%0d", k), n, 8);
      check($sformatf("blink_val%0d", k), led, exp_q.pop_front());
    end
    lock_pulse();
    check("blink_relock", status, 3'd0);

    // Two wrong attempts -> PAUSE; inputs ignored; back to LOC after 8 ticks
    enter_code(16'h1111);
    latch_pulse();
    check("pause_att1", attempts, 4'd1);
    enter_code(16'h1111);
    latch = 1'b0;
    cyc(1);
    latch = 1'b1;
    check("pause_status", status, 3'd2);
    check("pause_att0", attempts, 4'd0);
    check("pause_led", led, 8'h00);
    n = 1;
    while (status == 3'd2 && n < 40) begin
      if (n == 3) begin btn = 4'hF; switch = 4'h7; end
      if (n == 4) btn = 4'h0;
      if (n == 5) check("pause_btn_ignored", entry, 16'h0);
      if (n == 6) latch = 1'b0;
      if (n == 7) latch = 1'b1;
      if (n == 9) prog = 1'b1;
      if (n == 10) prog = 1'b0;
      cyc(1);
      n++;
    end
    check_range("pause_len", n, 29, 32);
    check("pause_exit_status", status, 3'd0);
    check("pause_exit_entry", entry, 16'h0);

    // Entry timeout: one digit, then idle
    load(0, 4'h9);
    check("to_entry", entry, 16'h0009);
    check("to_status_entry", status, 3'd4);
    cyc(30);
    check("to_still_armed", status, 3'd4);
    cyc(12);
    check("to_entry_clr", entry, 16'h0);
    check("to_status_loc", status, 3'd0);

    // Program a new code 1234
    enter_code(16'h3283);
    latch_pulse();
    check("pg_unlock", status, 3'd1);
    prog = 1'b1;
    cyc(1);
    prog = 1'b0;
    cyc(1);
    check("pg_status", status, 3'd3);
    check("pg_unlocked", unlocked, 1'b1);
    enter_code(16'h1234);
    check("pg_entry", entry, 16'h1234);
    latch_pulse();
    check("pg_store_status", status, 3'd1);
    check("pg_store_entry", entry, 16'h0);
    lock_pulse();
    check("pg_lock", status, 3'd0);
    enter_code(16'h1234);
    latch_pulse();
    check("pg_new_code", status, 3'd1);
    lock_pulse();
    enter_code(16'h3283);
    latch_pulse();
    check("pg_old_code_att", attempts, 4'd1);
    check("pg_old_code_status", status, 3'd0);

    // Reset in the middle of PAUSE discards the programmed code
    enter_code(16'h1111);
    latch = 1'b0;
    cyc(1);
    latch = 1'b1;
    check("rp_pause", status, 3'd2);
    cyc(3);
    rst_n = 1'b0;
    #1;
    check("rp_status", status, 3'd0);
    check("rp_entry", entry, 16'h0);
    check("rp_attempts", attempts, 4'd0);
    check("rp_unlocked", unlocked, 1'b0);
    check("rp_led", led, 8'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check("rp_after_status", status, 3'd0);
    enter_code(16'h3283);
    latch_pulse();
    check("rp_code_init", status, 3'd1);
    check("rp_code_unl", unlocked, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
